// File: rtl/test_monitor.sv
// Self-test supervisor: folds N result/done pairs into a sticky PASS/FAIL/TIMEOUT verdict plus LED code; `TEST_MONITOR_BLINK_EN` enables the blink code (else led = pass).
// Latency 1 cycle, all outputs registered; no backpressure, inputs are ignored once a verdict is reached.
module test_monitor #(
  parameter int N_TESTS        = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int BLINK_PERIOD   = 6000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_TESTS-1:0] result_in,
  input  logic [N_TESTS-1:0] done_in,
  output logic               finished,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [3:0]         fail_idx,
  output logic               led
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [N_TESTS-1:0] done_seen;
  logic [3:0]         low_idx;

`ifdef TEST_MONITOR_BLINK_EN
  localparam int            BW        = $clog2(4 * BLINK_PERIOD);
  localparam logic [BW-1:0] PHASE_END = BW'(BLINK_PERIOD - 1);
  localparam logic [BW-1:0] HALF_END  = BW'(BLINK_PERIOD / 2 - 1);
  localparam logic [BW-1:0] GAP_END   = BW'(4 * BLINK_PERIOD - 1);

  logic [BW-1:0] blink_cnt;
  logic [3:0]    pulse_cnt;
  logic          in_gap;
`endif

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    low_idx = 4'd0;
    for (int i = N_TESTS - 1; i >= 0; i--) begin
      if (result_in[i]) low_idx = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      cycle_cnt <= '0;
      done_seen <= '0;
      fail_idx  <= 4'd0;
      finished  <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      led       <= 1'b0;
`ifdef TEST_MONITOR_BLINK_EN
      blink_cnt <= '0;
      pulse_cnt <= 4'd0;
      in_gap    <= 1'b0;
`endif
    end else begin
      case (state)
        S_RUN: begin
          done_seen <= done_seen | done_in;
          if (|result_in) begin
            state    <= S_FAIL;
            fail     <= 1'b1;
            finished <= 1'b1;
            fail_idx <= low_idx;
`ifdef TEST_MONITOR_BLINK_EN
            led      <= 1'b1;
`endif
          end else if (&(done_seen | done_in)) begin
            state    <= S_PASS;
            pass     <= 1'b1;
            finished <= 1'b1;
            led      <= 1'b1;
          end else if (cycle_cnt == CNT_LAST) begin
            state    <= S_TIMEOUT;
            timeout  <= 1'b1;
            finished <= 1'b1;
`ifdef TEST_MONITOR_BLINK_EN
            led      <= 1'b1;
`endif
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
`ifdef TEST_MONITOR_BLINK_EN
        // Blink counters are still zero on entry: they only move in terminal states.
        S_TIMEOUT: begin
          if (blink_cnt == HALF_END) begin
            blink_cnt <= '0;
            led       <= ~led;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
        S_FAIL: begin
          if (in_gap) begin
            if (blink_cnt == GAP_END) begin
              blink_cnt <= '0;
              in_gap    <= 1'b0;
              pulse_cnt <= 4'd0;
              led       <= 1'b1;
            end else begin
              blink_cnt <= blink_cnt + BW'(1);
            end
          end else if (blink_cnt == PHASE_END) begin
            blink_cnt <= '0;
            if (led) begin
              led <= 1'b0;
            end else if (pulse_cnt == fail_idx) begin
              in_gap <= 1'b1;
            end else begin
              pulse_cnt <= pulse_cnt + 4'd1;
              led       <= 1'b1;
            end
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_monitor.sv
// Bench for test_monitor (N_TESTS=2, TIMEOUT_CYCLES=20, BLINK_PERIOD=4): table of scenarios plus a mid-blink reset sequence.
module tb_test_monitor;

  localparam int BP      = 4;
  localparam int RUN_LEN = 48;
  localparam int V_NONE  = 0;
  localparam int V_PASS  = 1;
  localparam int V_FAIL  = 2;
  localparam int V_TO    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] result_in;
  logic [1:0] done_in;
  logic       finished, pass, fail, timeout, led;
  logic [3:0] fail_idx;

  test_monitor #(.N_TESTS(2), .TIMEOUT_CYCLES(20), .BLINK_PERIOD(BP)) dut (
    .clk(clk), .rst(rst), .result_in(result_in), .done_in(done_in),
    .finished(finished), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_idx(fail_idx), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         a_from, a_to;
    logic [1:0] a_done, a_res;
    int         b_from, b_to;
    logic [1:0] b_done, b_res;
    int         exp_v, exp_edge;
    logic [3:0] exp_idx;
  } vec_t;

  typedef struct {
    int         scen;
    int         cyc;
    logic [8:0] val;
  } exp_t;

  vec_t vt[9];
  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // {finished, pass, fail, timeout, fail_idx[3:0], led}; k = cycles since verdict entry
  function automatic logic [8:0] expect_out(int v, logic [3:0] idx, int k);
    logic led_e;
    int   np, per, m;
    led_e = 1'b0;
    if (v == V_PASS) led_e = 1'b1;
    if (v == V_TO) led_e = ((k / (BP / 2)) % 2) == 0;
    if (v == V_FAIL) begin
      np    = int'(idx) + 1;
      per   = np * 2 * BP + 4 * BP;
      m     = k % per;
      led_e = (m < np * 2 * BP) && ((m % (2 * BP)) < BP);
    end
`ifndef TEST_MONITOR_BLINK_EN
    led_e = (v == V_PASS);
`endif
    return {v != V_NONE, v == V_PASS, v == V_FAIL, v == V_TO,
            (v == V_FAIL) ? idx : 4'd0, led_e};
  endfunction

  task automatic check();
    exp_t       e;
    logic [8:0] got;
    e   = sb.pop_front();
    got = {finished, pass, fail, timeout, fail_idx, led};
    vectors++;
    if (got !== e.val) begin
      miscompares++;
      $display("FAIL scen %0d cyc %0d: got fin/pass/fail/to/idx/led=%b required %b",
               e.scen, e.cyc, got, e.val);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] d, input logic [1:0] res,
                      input int scen, input int cyc, input logic [8:0] exp_val);
    exp_t e;
    rst       = r;
    done_in   = d;
    result_in = res;
    e.scen = scen;
    e.cyc  = cyc;
    e.val  = exp_val;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check();
  endtask

  initial begin
    logic [1:0] d, r;
    int         v;

    rst = 1'b1; done_in = 2'b00; result_in = 2'b00;

    //        a_from a_to a_done a_res  b_from b_to b_done b_res  verdict edge idx
    vt[0] = '{3,  3,  2'b01, 2'b00,  7,  7,  2'b10, 2'b00, V_PASS, 7,  4'd0}; // pulsed dones
    vt[1] = '{5,  8,  2'b00, 2'b10,  9,  47, 2'b00, 2'b11, V_FAIL, 5,  4'd1}; // dual failure
    vt[2] = '{-1, -1, 2'b00, 2'b00,  -1, -1, 2'b00, 2'b00, V_TO,   19, 4'd0}; // idle -> timeout
    vt[3] = '{19, 19, 2'b11, 2'b01,  -1, -1, 2'b00, 2'b00, V_FAIL, 19, 4'd0}; // all three at once
    vt[4] = '{19, 19, 2'b11, 2'b00,  -1, -1, 2'b00, 2'b00, V_PASS, 19, 4'd0}; // done beats timeout
    vt[5] = '{2,  2,  2'b11, 2'b00,  6,  47, 2'b00, 2'b10, V_PASS, 2,  4'd0}; // late result ignored
    vt[6] = '{4,  4,  2'b11, 2'b11,  -1, -1, 2'b00, 2'b00, V_FAIL, 4,  4'd0}; // result beats done
    vt[7] = '{1,  47, 2'b01, 2'b00,  12, 12, 2'b10, 2'b00, V_PASS, 12, 4'd0}; // level + pulse
    vt[8] = '{0,  47, 2'b01, 2'b00,  -1, -1, 2'b00, 2'b00, V_TO,   19, 4'd0}; // partial done

    for (int s = 0; s < 9; s++) begin
      step(1'b1, 2'b00, 2'b00, s, -2, expect_out(V_NONE, 4'd0, 0));
      step(1'b1, 2'b00, 2'b00, s, -1, expect_out(V_NONE, 4'd0, 0));
      for (int c = 0; c < RUN_LEN; c++) begin
        d = 2'b00;
        r = 2'b00;
        if (c >= vt[s].a_from && c <= vt[s].a_to) begin
          d = d | vt[s].a_done;
          r = r | vt[s].a_res;
        end
        if (c >= vt[s].b_from && c <= vt[s].b_to) begin
          d = d | vt[s].b_done;
          r = r | vt[s].b_res;
        end
        v = (c >= vt[s].exp_edge) ? vt[s].exp_v : V_NONE;
        step(1'b0, d, r, s, c, expect_out(v, vt[s].exp_idx, c - vt[s].exp_edge));
      end
    end

    // Mid-blink reset: FAIL at edge 2, 1-cycle reset during the blink, then a fresh run to PASS.
    step(1'b1, 2'b00, 2'b00, 100, -1, expect_out(V_NONE, 4'd0, 0));
    for (int c = 0; c < 13; c++) begin
      r = (c >= 2) ? 2'b01 : 2'b00;
      v = (c >= 2) ? V_FAIL : V_NONE;
      step(1'b0, 2'b00, r, 100, c, expect_out(v, 4'd0, c - 2));
    end
    step(1'b1, 2'b00, 2'b01, 101, -1, expect_out(V_NONE, 4'd0, 0));
    for (int c = 0; c < 15; c++) begin
      d = (c == 10) ? 2'b11 : 2'b00;
      v = (c >= 10) ? V_PASS : V_NONE;
      step(1'b0, d, 2'b00, 101, c, expect_out(v, 4'd0, c - 10));
    end

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
